ball_renderer: RTL and testbench



---
 rtl/ball_renderer_pkg.sv | 20 ++
 rtl/ball_renderer_bounce_axis.sv | 56 +++++
 rtl/ball_renderer.sv | 135 +++++++++++++
 tb/tb_ball_renderer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_renderer_pkg.sv
// rtl/ball_renderer_pkg.sv - shared state encoding, colours and centre helper for ball_renderer
package ball_renderer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [11:0] DEF_BG_COLOR   = 12'h000;
  localparam logic [11:0] DEF_WALL_COLOR = 12'hFFF;
  localparam logic [11:0] DEF_BALL_COLOR = 12'hF80;

  // Top-left corner that places the ball in the middle of an axis.
  function automatic int centre(input int active, input int size);
    return (active - size) / 2;
  endfunction

endpackage

// File: rtl/ball_renderer_bounce_axis.sv
// rtl/ball_renderer_bounce_axis.sv - one axis of ball motion with wall bounce
module bounce_axis #(
  parameter int ACTIVE    = 640,
  parameter int BORDER    = 8,
  parameter int BALL_SIZE = 16,
  parameter int SPEED     = 2,
  parameter int CENTRE    = 312
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       move,
  output logic [9:0] pos,
  output logic       dir,
  output logic       bounce
);

  localparam logic signed [10:0] LO         = 11'(BORDER);
  localparam logic signed [10:0] HI         = 11'(ACTIVE - BORDER - BALL_SIZE);
  localparam logic signed [10:0] STEP       = 11'(SPEED);
  localparam logic [9:0]         LO_POS     = 10'(BORDER);
  localparam logic [9:0]         HI_POS     = 10'(ACTIVE - BORDER - BALL_SIZE);
  localparam logic [9:0]         CENTRE_POS = 10'(CENTRE);

  logic signed [10:0] nxt;
  logic               under;
  logic               over;

  // dir=1 means moving towards lower coordinates; the extra bit keeps pos-SPEED from wrapping.
  assign nxt    = dir ? $signed({1'b0, pos}) - STEP : $signed({1'b0, pos}) + STEP;
  assign under  = nxt < LO;
  assign over   = nxt > HI;
  assign bounce = tick && move && !load && (under || over);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= CENTRE_POS;
      dir <= 1'b0;
    end else if (tick && load) begin
      pos <= CENTRE_POS;
      dir <= 1'b0;
    end else if (tick && move) begin
      if (under) begin
        pos <= LO_POS;
        dir <= 1'b0;
      end else if (over) begin
        pos <= HI_POS;
        dir <= 1'b1;
      end else begin
        pos <= nxt[9:0];
      end
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - bouncing-ball pixel generator behind the VGA timing generator
module ball_renderer
  import ball_renderer_pkg::*;
#(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          BALL_SIZE  = 16,
  parameter int          SPEED      = 2,
  parameter int          BORDER     = 8,
  parameter logic [11:0] BG_COLOR   = DEF_BG_COLOR,
  parameter logic [11:0] WALL_COLOR = DEF_WALL_COLOR,
  parameter logic [11:0] BALL_COLOR = DEF_BALL_COLOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic       blank,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       serve,
  input  logic       run,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       hit,
  output logic [7:0] bounce_count
);

  localparam int          CENTRE_X  = centre(H_ACTIVE, BALL_SIZE);
  localparam int          CENTRE_Y  = centre(V_ACTIVE, BALL_SIZE);
  localparam logic [10:0] X_WALL_LO = 11'(BORDER);
  localparam logic [10:0] X_WALL_HI = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] Y_WALL_LO = 11'(BORDER);
  localparam logic [10:0] Y_WALL_HI = 11'(V_ACTIVE - BORDER);
  localparam logic [10:0] SIZE11    = 11'(BALL_SIZE);
  localparam logic [9:0]  LAST_LINE = 10'(V_ACTIVE - 1);

  state_t      state;
  logic        prev_blank;
  logic        tick;
  logic        load;
  logic        move;
  logic [9:0]  bx;
  logic [9:0]  by;
  logic        bounce_x;
  logic        bounce_y;
  logic        unused_dir_x;
  logic        unused_dir_y;
  logic [10:0] x11;
  logic [10:0] y11;
  logic        in_wall;
  logic        in_ball;
  logic [11:0] colour;

  // Falling edge of the visible flag on the last line: the frame's final pixel is done.
  assign tick = strobe && prev_blank && !blank && (ypos == LAST_LINE);
  assign load = (state == SERVE);
  assign move = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (serve) begin
      state <= SERVE;
    end else begin
      case (state)
        IDLE:    state <= IDLE;
        SERVE:   if (tick) state <= RUN;
        RUN:     if (!run) state <= PAUSE;
        PAUSE:   if (run) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  bounce_axis #(
    .ACTIVE(H_ACTIVE), .BORDER(BORDER), .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .CENTRE(CENTRE_X)
  ) u_axis_x (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .move(move),
    .pos(bx), .dir(unused_dir_x), .bounce(bounce_x)
  );

  bounce_axis #(
    .ACTIVE(V_ACTIVE), .BORDER(BORDER), .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .CENTRE(CENTRE_Y)
  ) u_axis_y (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .move(move),
    .pos(by), .dir(unused_dir_y), .bounce(bounce_y)
  );

  assign x11     = {1'b0, xpos};
  assign y11     = {1'b0, ypos};
  assign in_wall = (x11 < X_WALL_LO) || (x11 >= X_WALL_HI) ||
                   (y11 < Y_WALL_LO) || (y11 >= Y_WALL_HI);
  assign in_ball = (x11 >= {1'b0, bx}) && (x11 < {1'b0, bx} + SIZE11) &&
                   (y11 >= {1'b0, by}) && (y11 < {1'b0, by} + SIZE11);

  always_comb begin
    colour = BG_COLOR;
    if (!blank)       colour = 12'h000;
    else if (in_wall) colour = WALL_COLOR;
    else if (in_ball) colour = BALL_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red        <= 4'h0;
      green      <= 4'h0;
      blue       <= 4'h0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      prev_blank <= 1'b0;
    end else if (strobe) begin
      {red, green, blue} <= colour;
      hsync_out          <= hsync_in;
      vsync_out          <= vsync_in;
      prev_blank         <= blank;
    end
  end

  // A corner bounce counts once: both axes fold into a single event.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit          <= 1'b0;
      bounce_count <= 8'd0;
    end else begin
      hit <= bounce_x || bounce_y;
      if (bounce_x || bounce_y) bounce_count <= bounce_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - scoreboard bench for ball_renderer against a frame-level model
module tb_ball_renderer;

  localparam int HA = 640, VA = 480, SZ = 16, BD = 8, SP = 2;
  localparam int X_HI = HA - BD - SZ, Y_HI = VA - BD - SZ;
  localparam int CX = (HA - SZ) / 2, CY = (VA - SZ) / 2;
  localparam int M_IDLE = 0, M_SERVING = 1, M_ACTIVE = 2;

  logic       clk = 1'b0;
  logic       rst, strobe, blank, hsync_in, vsync_in, serve, run;
  logic [9:0] xpos, ypos;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, hit;
  logic [7:0] bounce_count;

  always #5 clk = ~clk;

  ball_renderer dut (
    .clk(clk), .rst(rst), .strobe(strobe), .xpos(xpos), .ypos(ypos), .blank(blank),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .serve(serve), .run(run),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hit(hit), .bounce_count(bounce_count)
  );

  typedef struct {int rgb; int hs; int vs; int hit; int cnt;} exp_t;
  exp_t sbq[$];
  exp_t last;
  int   n_cmp = 0, n_bad = 0;

  int mbx, mby, mdx, mdy, mcount, mstate;
  bit mprev_blank, corner_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, "_rgb"}, int'({red, green, blue}), e.rgb);
    chk({tag, "_hsync"}, int'(hsync_out), e.hs);
    chk({tag, "_vsync"}, int'(vsync_out), e.vs);
    chk({tag, "_hit"}, int'(hit), e.hit);
    chk({tag, "_count"}, int'(bounce_count), e.cnt);
  endtask

  // Monitor: outputs refresh after any strobe or reset edge, otherwise they must hold.
  bit s_strobe, s_rst;
  always @(posedge clk) begin
    s_strobe = strobe;
    s_rst    = rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_rst) begin
      e = '{0, 1, 1, 0, 0};
      cmp_all("reset", e);
      last = e;
    end else if (s_strobe) begin
      if (sbq.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sbq.pop_front();
        cmp_all("pixel", e);
        last = e;
        last.hit = 0;
      end
    end else begin
      cmp_all("hold", last);
    end
  end

  function automatic int colour_of(input int x, input int y, input bit b);
    if (!b) return 0;
    if (x < BD || x >= HA - BD || y < BD || y >= VA - BD) return 'hFFF;
    if (x >= mbx && x < mbx + SZ && y >= mby && y < mby + SZ) return 'hF80;
    return 'h000;
  endfunction

  task automatic model_reset();
    mbx = CX; mby = CY; mdx = 1; mdy = 1;
    mcount = 0; mstate = M_IDLE; mprev_blank = 0;
  endtask

  task automatic step(inout int p, inout int d, input int hi, output bit b);
    int n;
    n = p + SP * d;
    b = 1;
    if (n < BD) begin p = BD; d = 1; end
    else if (n > hi) begin p = hi; d = -1; end
    else begin p = n; b = 0; end
  endtask

  task automatic model_tick(output int h);
    bit bxb, byb;
    h = 0;
    if (mstate == M_SERVING) begin
      mbx = CX; mby = CY; mdx = 1; mdy = 1; mstate = M_ACTIVE;
    end else if (mstate == M_ACTIVE && run) begin
      step(mbx, mdx, X_HI, bxb);
      step(mby, mdy, Y_HI, byb);
      if (bxb || byb) begin
        h = 1;
        mcount = (mcount + 1) % 256;
      end
      if (bxb && byb) corner_seen = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    strobe   = 1'b0;
    xpos     = 10'($urandom_range(0, 639));
    ypos     = 10'($urandom_range(0, 479));
    blank    = 1'($urandom_range(0, 1));
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
  endtask

  task automatic pix(input int x, input int y, input bit b);
    exp_t e;
    bit   tk;
    repeat ($urandom_range(0, 2)) begin
      cyc();
      garbage();
    end
    cyc();
    strobe = 1'b1; xpos = 10'(x); ypos = 10'(y); blank = b;
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    tk = mprev_blank && !b && (y == VA - 1);
    mprev_blank = b;
    e.rgb = colour_of(x, y, b);
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.hit = 0;
    if (tk) model_tick(e.hit);
    e.cnt = mcount;
    sbq.push_back(e);
  endtask

  task automatic frame(input bit full);
    if (full) begin
      pix(mbx, mby, 1);          pix(mbx + 15, mby + 15, 1);
      pix(mbx - 1, mby + 3, 1);  pix(mbx + 16, mby + 8, 1);
      pix(mbx + 5, mby - 1, 1);  pix(mbx + 7, mby + 16, 1);
      pix(7, $urandom_range(8, 471), 1);   pix(8, $urandom_range(8, 471), 1);
      pix(631, $urandom_range(8, 471), 1); pix(632, $urandom_range(8, 471), 1);
      pix($urandom_range(8, 631), 7, 1);   pix($urandom_range(8, 631), 472, 1);
      pix($urandom_range(0, 639), $urandom_range(0, 478), 1);
      pix(639, $urandom_range(0, 478), 0);
    end
    pix($urandom_range(0, 639), VA - 1, 1);
    pix(HA - 1, VA - 1, 0);
  endtask

  task automatic do_serve();
    cyc(); garbage(); serve = 1'b1;
    mstate = M_SERVING;
    cyc(); serve = 1'b0;
  endtask

  task automatic set_run(input bit v);
    cyc(); garbage(); run = v;
  endtask

  initial begin
    int guard;
    rst = 1'b1; strobe = 1'b0; xpos = '0; ypos = '0; blank = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; serve = 1'b0; run = 1'b0;
    corner_seen = 0;
    model_reset();
    repeat (3) begin
      cyc(); garbage(); strobe = 1'($urandom_range(0, 1));
    end
    cyc(); rst = 1'b0; garbage();

    pix(320, 240, 1); pix(0, 0, 1); pix(100, 100, 1);
    pix(312, 232, 1); pix(327, 247, 1); pix(311, 232, 1); pix(328, 247, 1);
    frame(1); frame(1);

    do_serve(); set_run(1);
    repeat (11) frame(1);
    pix(332, 252, 1); pix(347, 267, 1); pix(331, 252, 1);

    guard = 0;
    while (!corner_seen && guard < 8000) begin
      frame(mbx >= X_HI - 6 || mbx <= BD + 6 || mby >= Y_HI - 6 || mby <= BD + 6 || guard % 50 == 0);
      guard++;
    end
    chk("corner_reached", int'(corner_seen), 1);
    frame(1); frame(1);

    set_run(0); repeat (5) frame(1);
    set_run(1); repeat (3) frame(1);
    set_run(0); do_serve(); frame(1); frame(1);

    cyc(); rst = 1'b1; strobe = 1'b1; xpos = 10'd300; ypos = 10'd240; blank = 1'b1;
    cyc(); rst = 1'b0; garbage();
    model_reset();
    pix(HA - 1, VA - 1, 0);
    set_run(1); frame(1); frame(1);
    do_serve(); frame(1); frame(1);

    repeat (3) begin
      cyc(); garbage();
    end
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
